// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Checks a received 4-bit XNOR LFSR word stream (successor {x[2:0], ~(x[3]^x[2])})
// against a local reference. The checker hunts for a seed, confirms it over
// LOCK_MATCHES correct successors, then flywheels its reference while locked,
// counting mismatches. After UNLOCK_ERRS consecutive mismatches it drops lock.
//
// Ports:
//   clock       in   1  rising-edge clock
//   reset_n     in   1  asynchronous active-low reset
//   data_valid  in   1  data_in carries a word this cycle
//   data_in     in   4  received LFSR word
//   clear_errs  in   1  synchronous clear of err_count
//   locked      out  1  registered, high while in LOCKED
//   error       out  1  one-cycle pulse after a mismatching word while locked
//   err_count   out  8  saturating error count
//   lockup      out  1  one-cycle pulse after receipt of the illegal word 1111
// -----------------------------------------------------------------------------
module lfsr_checker #(
   parameter int LOCK_MATCHES = 3,
   parameter int UNLOCK_ERRS  = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       data_valid,
   input  logic [3:0] data_in,
   input  logic       clear_errs,
   output logic       locked,
   output logic       error,
   output logic [7:0] err_count,
   output logic       lockup
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT   = 4'(LOCK_MATCHES);
   localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_ERRS);
   localparam logic [3:0] ILLEGAL    = 4'b1111;

   // Successor of the XNOR LFSR; 1111 is its fixed point.
   function automatic logic [3:0] nxt(input logic [3:0] x);
      return {x[2:0], ~(x[3] ^ x[2])};
   endfunction

   state_t     state_r, state_s;
   logic [3:0] ref_r, ref_s;
   logic [3:0] match_cnt_r, match_cnt_s;
   logic [3:0] err_run_r, err_run_s;
   logic       error_s;
   logic       lockup_s;
   logic       err_inc_s;
   logic [3:0] expect_s;

   // Next-state logic: only valid words advance the checker.
   always_comb begin
      state_s     = state_r;
      ref_s       = ref_r;
      match_cnt_s = match_cnt_r;
      err_run_s   = err_run_r;
      error_s     = 1'b0;
      lockup_s    = 1'b0;
      err_inc_s   = 1'b0;
      expect_s    = nxt(ref_r);
      if (data_valid) begin
         case (state_r)
            HUNT: begin
               if (data_in == ILLEGAL) begin
                  lockup_s = 1'b1;
               end else begin
                  ref_s       = data_in;
                  match_cnt_s = 4'd0;
                  state_s     = SYNC;
               end
            end
            SYNC: begin
               // ref is never 1111 here, so a correct successor is never illegal.
               if (data_in == expect_s) begin
                  ref_s       = data_in;
                  match_cnt_s = match_cnt_r + 4'd1;
                  if ((match_cnt_r + 4'd1) == LOCK_CNT) begin
                     state_s   = LOCKED;
                     err_run_s = 4'd0;
                  end else begin
                     state_s = SYNC;
                  end
               end else if (data_in == ILLEGAL) begin
                  lockup_s = 1'b1;
                  state_s  = HUNT;
               end else begin
                  ref_s       = data_in;
                  match_cnt_s = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel: reference advances regardless of what was received.
               ref_s = expect_s;
               if (data_in == expect_s) begin
                  err_run_s = 4'd0;
               end else begin
                  error_s   = 1'b1;
                  err_inc_s = 1'b1;
                  err_run_s = err_run_r + 4'd1;
                  if ((err_run_r + 4'd1) == UNLOCK_CNT) begin
                     state_s = HUNT;
                  end else begin
                     state_s = LOCKED;
                  end
               end
               if (data_in == ILLEGAL) begin
                  lockup_s = 1'b1;
               end else begin
                  lockup_s = lockup_s;
               end
            end
            default: begin
               state_s     = HUNT;
               ref_s       = 4'd0;
               match_cnt_s = 4'd0;
               err_run_s   = 4'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, reference, counters and registered pulse outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= HUNT;
         ref_r       <= 4'd0;
         match_cnt_r <= 4'd0;
         err_run_r   <= 4'd0;
         locked      <= 1'b0;
         error       <= 1'b0;
         lockup      <= 1'b0;
      end else begin
         state_r     <= state_s;
         ref_r       <= ref_s;
         match_cnt_r <= match_cnt_s;
         err_run_r   <= err_run_s;
         locked      <= (state_s == LOCKED);
         error       <= error_s;
         lockup      <= lockup_s;
      end
   end

   // Saturating error counter; clear wins over a simultaneous increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= 8'd0;
      end else if (clear_errs) begin
         err_count <= 8'd0;
      end else if (err_inc_s && (err_count != 8'd255)) begin
         err_count <= err_count + 8'd1;
      end else begin
         err_count <= err_count;
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

   logic       clock;
   logic       reset_n;
   logic       data_valid;
   logic [3:0] data_in;
   logic       clear_errs;
   logic       locked;
   logic       error;
   logic [7:0] err_count;
   logic       lockup;

   int checks;
   int errors;

   lfsr_checker #(.LOCK_MATCHES(3), .UNLOCK_ERRS(2)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .data_valid (data_valid),
      .data_in    (data_in),
      .clear_errs (clear_errs),
      .locked     (locked),
      .error      (error),
      .err_count  (err_count),
      .lockup     (lockup)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [3:0] succ(input logic [3:0] x);
      return {x[2:0], ~(x[3] ^ x[2])};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      data_valid = v;
      data_in    = d;
      clear_errs = c;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic l, input logic e,
                          input logic [7:0] n, input logic k);
      chk({tag, ".locked"}, {7'd0, locked}, {7'd0, l});
      chk({tag, ".error"}, {7'd0, error}, {7'd0, e});
      chk({tag, ".err_count"}, err_count, n);
      chk({tag, ".lockup"}, {7'd0, lockup}, {7'd0, k});
   endtask

   logic [3:0] r;
   logic [3:0] w;
   int         nerr;

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      data_valid = 1'b0;
      data_in    = 4'd0;
      clear_errs = 1'b0;
      #2;
      chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b0);
      #1 reset_n = 1'b1;

      // Lock acquisition from reset
      step(1'b1, 4'b0000, 1'b0); chk_all("acq0", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b0001, 1'b0); chk_all("acq1", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b0011, 1'b0); chk_all("acq2", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b0111, 1'b0); chk_all("acq3", 1'b1, 1'b0, 8'd0, 1'b0);

      // Single error, flywheel keeps the reference on track
      step(1'b1, 4'b0000, 1'b0); chk_all("fly_err", 1'b1, 1'b1, 8'd1, 1'b0);
      step(1'b1, 4'b1101, 1'b0); chk_all("fly_ok", 1'b1, 1'b0, 8'd1, 1'b0);
      step(1'b1, 4'b1011, 1'b0); chk_all("fly_ok2", 1'b1, 1'b0, 8'd1, 1'b0);

      // Idle clear: no state change, error reads 0
      step(1'b0, 4'b0000, 1'b1); chk_all("clr_idle", 1'b1, 1'b0, 8'd0, 1'b0);

      // Loss of lock after two consecutive wrong words (expected 0110, 1100)
      step(1'b1, 4'b0000, 1'b0); chk_all("lose1", 1'b1, 1'b1, 8'd1, 1'b0);
      step(1'b1, 4'b0000, 1'b0); chk_all("lose2", 1'b0, 1'b1, 8'd2, 1'b0);
      // Relock after 1+LOCK_MATCHES correct words
      step(1'b1, 4'b1100, 1'b0); chk_all("relock0", 1'b0, 1'b0, 8'd2, 1'b0);
      step(1'b1, 4'b1001, 1'b0); chk_all("relock1", 1'b0, 1'b0, 8'd2, 1'b0);
      step(1'b1, 4'b0010, 1'b0); chk_all("relock2", 1'b0, 1'b0, 8'd2, 1'b0);
      step(1'b1, 4'b0101, 1'b0); chk_all("relock3", 1'b1, 1'b0, 8'd2, 1'b0);

      // Illegal word while locked: mismatch plus lockup (expected 1010)
      step(1'b1, 4'b1111, 1'b0); chk_all("lk_1111", 1'b1, 1'b1, 8'd3, 1'b1);
      // Gap cycle clears the pulses
      step(1'b0, 4'b1111, 1'b0); chk_all("lk_gap", 1'b1, 1'b0, 8'd3, 1'b0);

      // Asynchronous reset while locked
      #2 reset_n = 1'b0;
      #1 chk_all("async_rst", 1'b0, 1'b0, 8'd0, 1'b0);
      #1 reset_n = 1'b1;

      // 1111 in HUNT
      step(1'b1, 4'b1111, 1'b0); chk_all("hunt_1111", 1'b0, 1'b0, 8'd0, 1'b1);
      step(1'b1, 4'b0110, 1'b0); chk_all("to_sync", 1'b0, 1'b0, 8'd0, 1'b0);
      // 1111 in SYNC returns to HUNT
      step(1'b1, 4'b1111, 1'b0); chk_all("sync_1111", 1'b0, 1'b0, 8'd0, 1'b1);

      // Lock with gaps; a stale SYNC state with ref 0110 would lock one word early
      step(1'b1, 4'b1100, 1'b0); chk_all("gap_w0", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b0, 4'b1111, 1'b0); chk_all("gap_i0", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b1001, 1'b0); chk_all("gap_w1", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0); chk_all("gap_i1", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b0010, 1'b0); chk_all("gap_w2", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b0, 4'b0000, 1'b0); chk_all("gap_i2", 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b1, 4'b0101, 1'b0); chk_all("gap_w3", 1'b1, 1'b0, 8'd0, 1'b0);

      // Saturation: alternate wrong/correct words to stay locked
      r    = 4'b0101;
      nerr = 0;
      for (int i = 0; i < 260; i++) begin
         w = succ(r) ^ 4'b0001;
         r = succ(r);
         step(1'b1, w, 1'b0);
         nerr++;
         if (nerr == 1 || nerr == 254 || nerr == 255 || nerr == 256 || nerr == 260) begin
            chk($sformatf("sat_cnt%0d", nerr), err_count, (nerr > 255) ? 8'd255 : 8'(nerr));
            chk($sformatf("sat_err%0d", nerr), {7'd0, error}, 8'd1);
            chk($sformatf("sat_lock%0d", nerr), {7'd0, locked}, 8'd1);
         end
         r = succ(r);
         step(1'b1, r, 1'b0);
      end
      chk("sat_final", err_count, 8'd255);

      // Clear in the same cycle as an error: clear wins, error still pulses
      w = succ(r) ^ 4'b0010;
      r = succ(r);
      step(1'b1, w, 1'b1); chk_all("clr_err", 1'b1, 1'b1, 8'd0, 1'b0);
      r = succ(r);
      step(1'b1, r, 1'b0); chk_all("after_clr", 1'b1, 1'b0, 8'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
